// File: rtl/iomem_initiator.sv
// PicoSoC iomem bus master: turns one accepted command into one iomem transfer and
// returns captured read data, or an error word when the responder never answers.
module iomem_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
    input  logic        clk100,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] txn_count,
    output logic [7:0]  tmo_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [15:0] timer_q, timer_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;
    logic [15:0] txn_q,   txn_d;
    logic [7:0]  tmo_q,   tmo_d;

    // Next-state and datapath updates for the IDLE -> REQ -> RSP transfer sequence
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        timer_d = timer_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        txn_d   = txn_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    // Reads never drive byte enables, whatever the command carried
                    wstrb_d = cmd_we ? cmd_wstrb : 4'b0000;
                    timer_d = 16'd0;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A ready arriving on the last allowed cycle still counts as success
                if (iomem_ready) begin
                    rdata_d = iomem_rdata;
                    err_d   = 1'b0;
                    txn_d   = txn_q + 16'd1;
                    state_d = ST_RSP;
                end else if (timer_q == TMO_LAST) begin
                    rdata_d = ERR_RDATA;
                    err_d   = 1'b1;
                    tmo_d   = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
                    state_d = ST_RSP;
                end else begin
                    timer_d = timer_q + 16'd1;
                    state_d = ST_REQ;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk100) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            timer_q <= 16'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            txn_q   <= 16'd0;
            tmo_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            timer_q <= timer_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            txn_q   <= txn_d;
            tmo_q   <= tmo_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign iomem_valid = (state_q == ST_REQ);
    assign rsp_valid   = (state_q == ST_RSP);
    assign iomem_addr  = addr_q;
    assign iomem_wdata = wdata_q;
    assign iomem_wstrb = wstrb_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign txn_count   = txn_q;
    assign tmo_count   = tmo_q;

endmodule

// File: tb/tb_iomem_initiator.sv
// Directed bench for iomem_initiator: a small responder model drives iomem_ready,
// expected responses are queued at issue time and checked by an independent monitor.
module tb_iomem_initiator;

    logic        clk100 = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] txn_count;
    logic [7:0]  tmo_count;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  led   = 8'h00;
    int          vcount;

    iomem_initiator dut (
        .clk100      (clk100),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .txn_count   (txn_count),
        .tmo_count   (tmo_count)
    );

    always #5 clk100 = ~clk100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    // Issue one command and play the responder: ready in the lat-th valid cycle (0 = never).
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [3:0] exp_wstrb,
                          input int lat, input logic [31:0] resp, input rsp_t exp);
        int guard;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
        guard = 0;
        while (!iomem_valid && guard < 20) begin
            tick();
            guard++;
        end
        cmd_valid = 1'b0;
        if (!iomem_valid) begin
            chk("accept_timeout", {31'd0, iomem_valid}, 32'd1);
            return;
        end
        exp_q.push_back(exp);
        vcount = 0;
        while (iomem_valid && vcount < 400) begin
            vcount++;
            chk("addr_stable", iomem_addr, addr);
            chk("wstrb_stable", {28'd0, iomem_wstrb}, {28'd0, exp_wstrb});
            if (vcount == lat) begin
                iomem_ready = 1'b1;
                iomem_rdata = resp;
                if (we && iomem_wstrb[0]) led = iomem_wdata[7:0];
            end
            tick();
            iomem_ready = 1'b0;
            iomem_rdata = 32'h0BAD_0BAD;
        end
        chk("rsp_valid_latency", {31'd0, rsp_valid}, 32'd1);
    endtask

    // Scoreboard monitor: every handshaken response is compared with the oldest expectation
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk100);
            if (resetn && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                end
            end
        end
    end

    initial begin
        logic [31:0] held;
        resetn      = 1'b0;
        cmd_valid   = 1'b0;
        cmd_we      = 1'b0;
        cmd_addr    = 32'd0;
        cmd_wdata   = 32'd0;
        cmd_wstrb   = 4'd0;
        iomem_ready = 1'b0;
        iomem_rdata = 32'h0BAD_0BAD;
        rsp_ready   = 1'b1;
        repeat (3) tick();
        resetn = 1'b1;

        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_iomem_valid", {31'd0, iomem_valid}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_iomem_addr", iomem_addr, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_txn", {16'd0, txn_count}, 32'd0);
        chk("rst_tmo", {24'd0, tmo_count}, 32'd0);

        // Write to GPIO, responder answers one cycle after valid
        do_txn(1'b1, 32'h0300_0000, 32'h0000_00A5, 4'b0001, 4'b0001, 2,
               32'hDEAD_0001, '{32'hDEAD_0001, 1'b0});
        chk("wr_vcount", vcount, 32'd2);
        chk("wr_led", {24'd0, led}, 32'h0000_00A5);
        tick();
        chk("wr_txn", {16'd0, txn_count}, 32'd1);

        // Read with byte enables offered; bus must see none
        do_txn(1'b0, 32'h0300_0000, 32'h1111_1111, 4'hF, 4'h0, 1,
               32'h00C3_00A5, '{32'h00C3_00A5, 1'b0});
        chk("rd_vcount", vcount, 32'd1);
        tick();
        chk("rd_txn", {16'd0, txn_count}, 32'd2);

        // Silent responder: abort after exactly 255 valid cycles
        do_txn(1'b0, 32'h0400_0000, 32'd0, 4'h0, 4'h0, 0,
               32'd0, '{32'hFFFF_FFFF, 1'b1});
        chk("tmo_vcount", vcount, 32'd255);
        tick();
        chk("tmo_tmo", {24'd0, tmo_count}, 32'd1);
        chk("tmo_txn", {16'd0, txn_count}, 32'd2);

        // Ready on the final allowed cycle wins over the timeout
        do_txn(1'b0, 32'h0300_0010, 32'd0, 4'h0, 4'h0, 255,
               32'h5555_AAAA, '{32'h5555_AAAA, 1'b0});
        chk("race_vcount", vcount, 32'd255);
        tick();
        chk("race_txn", {16'd0, txn_count}, 32'd3);
        chk("race_tmo", {24'd0, tmo_count}, 32'd1);

        // Stray ready while idle must be ignored
        iomem_ready = 1'b1;
        iomem_rdata = 32'hCAFE_F00D;
        tick();
        iomem_ready = 1'b0;
        tick();
        chk("stray_txn", {16'd0, txn_count}, 32'd3);
        chk("stray_tmo", {24'd0, tmo_count}, 32'd1);
        chk("stray_rdata", rsp_rdata, 32'h5555_AAAA);
        chk("stray_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Backpressure: response held for 5 cycles while the next command waits
        rsp_ready = 1'b0;
        do_txn(1'b0, 32'h0300_0020, 32'd0, 4'h0, 4'h0, 3,
               32'h1234_5678, '{32'h1234_5678, 1'b0});
        held      = 32'h1234_5678;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 32'h0300_0004;
        cmd_wdata = 32'h0000_005A;
        cmd_wstrb = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, held);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("bp_iomem_valid", {31'd0, iomem_valid}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        do_txn(1'b1, 32'h0300_0004, 32'h0000_005A, 4'b0011, 4'b0011, 1,
               32'h0000_0000, '{32'h0000_0000, 1'b0});
        tick();
        chk("bp_txn", {16'd0, txn_count}, 32'd5);
        chk("bp_led", {24'd0, led}, 32'h0000_005A);

        // Reset in the middle of a request
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 32'h0300_0030;
        for (int g = 0; g < 20 && !iomem_valid; g++) tick();
        cmd_valid = 1'b0;
        tick();
        chk("mid_valid_before", {31'd0, iomem_valid}, 32'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("mid_iomem_valid", {31'd0, iomem_valid}, 32'd0);
        chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_txn", {16'd0, txn_count}, 32'd0);
        chk("mid_tmo", {24'd0, tmo_count}, 32'd0);
        chk("mid_rsp_rdata", rsp_rdata, 32'd0);

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
